// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-arbiter state type.
package uart_pkg;

    localparam int unsigned CLKFREQ      = 12_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned FRAME_CYCLES = (CLKFREQ / BAUD) * 10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask after index last, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (mask[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one UART transmitter among N requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int LOCK_TO = 4096
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_last,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic                 uart_wr,
    output logic [7:0]           uart_dat,
    input  logic                 uart_busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 locked
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LOCK_TO + 1);

    arb_state_t    state;
    logic          first_wait;
    logic [CW-1:0] lock_cnt;
    logic [N-1:0]  owner_mask;
    logic [N-1:0]  eligible;
    logic [IW-1:0] pick;
    logic          any;

    assign owner_mask = N'(1) << owner;
    assign eligible   = locked ? (req & owner_mask) : req;

    rr_pick #(
        .N (N),
        .IW(IW)
    ) u_pick (
        .mask(eligible),
        .last(owner),
        .pick(pick),
        .any (any)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state      <= IDLE;
            uart_wr    <= 1'b0;
            uart_dat   <= '0;
            ack        <= '0;
            owner      <= IW'(N - 1);
            locked     <= 1'b0;
            lock_cnt   <= '0;
            first_wait <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!uart_busy && any) begin
                        uart_wr  <= 1'b1;
                        uart_dat <= req_data[8*pick +: 8];
                        ack      <= N'(1) << pick;
                        owner    <= pick;
                        locked   <= !req_last[pick];
                        lock_cnt <= '0;
                        state    <= ISSUE;
                    end else if (locked && !req[owner]) begin
                        // Owner went quiet mid-packet; give the line back after LOCK_TO cycles.
                        if (lock_cnt == CW'(LOCK_TO - 1)) begin
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + CW'(1);
                        end
                    end else begin
                        lock_cnt <= '0;
                    end
                end
                ISSUE: begin
                    uart_wr    <= 1'b0;
                    ack        <= '0;
                    first_wait <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    // busy only rises at the edge leaving ISSUE, so ignore it for one cycle.
                    first_wait <= 1'b0;
                    if (!first_wait && !uart_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
